// File: rtl/signal_neighborhood_fetch_pkg.sv
// Shared types and default geometry for the signal neighbourhood fetch block.
package signal_neighborhood_fetch_pkg;

  localparam int unsigned DEF_GRID_W      = 16;
  localparam int unsigned DEF_GRID_H      = 12;
  localparam int unsigned DEF_SIGNAL_bits = 16;
  localparam int unsigned DEF_LOC_bits    = $clog2(DEF_GRID_W * DEF_GRID_H);

  // Fetch slot counter: slot 0 is the centre, slots 1..8 are directions 0..7
  localparam int unsigned IDX_bits = 4;
  localparam int unsigned IDX_LAST = 8;

  typedef enum logic [2:0] {N, NE, E, SE, S, SW, W, NW} dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_PRESENT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/signal_neighborhood_fetch_addr_gen.sv
// Neighbour address and on-grid flag for one direction around cell (x, y).
module neighbor_addr_gen
  import signal_neighborhood_fetch_pkg::*;
#(
  parameter int unsigned GRID_W   = DEF_GRID_W,
  parameter int unsigned GRID_H   = DEF_GRID_H,
  parameter int unsigned LOC_bits = $clog2(GRID_W * GRID_H)
) (
  input  logic [LOC_bits-1:0] x,
  input  logic [LOC_bits-1:0] y,
  input  dir_t                dir,
  output logic [LOC_bits-1:0] addr,
  output logic                on_grid
);

  logic                xm, xp, ym, yp;
  logic [LOC_bits-1:0] nx, ny;

  // Decode direction into step flags, then step and bound-check from x/y compares
  always_comb begin
    xm = 1'b0;
    xp = 1'b0;
    ym = 1'b0;
    yp = 1'b0;
    case (dir)
      N:  ym = 1'b1;
      NE: begin ym = 1'b1; xp = 1'b1; end
      E:  xp = 1'b1;
      SE: begin yp = 1'b1; xp = 1'b1; end
      S:  yp = 1'b1;
      SW: begin yp = 1'b1; xm = 1'b1; end
      W:  xm = 1'b1;
      NW: begin ym = 1'b1; xm = 1'b1; end
      default: ;
    endcase

    nx = x;
    if (xp)      nx = x + LOC_bits'(1);
    else if (xm) nx = x - LOC_bits'(1);
    ny = y;
    if (yp)      ny = y + LOC_bits'(1);
    else if (ym) ny = y - LOC_bits'(1);

    on_grid = !(xm && (x == '0)) &&
              !(xp && (x == LOC_bits'(GRID_W - 1))) &&
              !(ym && (y == '0)) &&
              !(yp && (y == LOC_bits'(GRID_H - 1)));

    addr = ny * LOC_bits'(GRID_W) + nx;
  end

endmodule

// File: rtl/signal_neighborhood_fetch.sv
// Sweeps the grid row-major, reads each cell and its 8 neighbours from the
// signal RAM and presents the assembled neighbourhood over valid/ready.
module signal_neighborhood_fetch
  import signal_neighborhood_fetch_pkg::*;
#(
  parameter int unsigned GRID_W      = DEF_GRID_W,
  parameter int unsigned GRID_H      = DEF_GRID_H,
  parameter int unsigned SIGNAL_bits = DEF_SIGNAL_bits,
  parameter int unsigned LOC_bits    = $clog2(GRID_W * GRID_H)
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_rd_en,
  output logic [LOC_bits-1:0]          mem_rd_addr,
  input  logic [SIGNAL_bits-1:0]       mem_rd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LOC_bits-1:0]          out_loc,
  output logic [7:0][SIGNAL_bits-1:0]  surrounding_signals,
  output logic [SIGNAL_bits-1:0]       cur_signal
);

  state_t                        state, nxt_state;
  logic [IDX_bits-1:0]           idx, nxt_idx;
  logic [LOC_bits-1:0]           x, y, nxt_x, nxt_y;
  logic                          last_cell;
  logic [LOC_bits-1:0]           cur_loc, ctr_addr;

  dir_t                          nxt_dir;
  logic [LOC_bits-1:0]           nbr_addr;
  logic                          nbr_on_grid;

  logic                          busy_d, done_d, out_valid_d, rd_en_d, flag_we;
  logic [LOC_bits-1:0]           rd_addr_d;
  logic [7:0][SIGNAL_bits-1:0]   bundle;

  logic                          rd_pend;
  logic [IDX_bits-1:0]           rd_idx;
  logic [7:0][SIGNAL_bits-1:0]   slot;
  logic [8:1]                    sub_flag;

  assign last_cell = (x == LOC_bits'(GRID_W - 1)) && (y == LOC_bits'(GRID_H - 1));
  assign cur_loc   = y * LOC_bits'(GRID_W) + x;
  assign ctr_addr  = nxt_y * LOC_bits'(GRID_W) + nxt_x;
  assign nxt_dir   = dir_t'(3'(nxt_idx - IDX_bits'(1)));

  // Address of the neighbour that the upcoming fetch slot targets
  neighbor_addr_gen #(
    .GRID_W   (GRID_W),
    .GRID_H   (GRID_H),
    .LOC_bits (LOC_bits)
  ) u_addr_gen (
    .x       (nxt_x),
    .y       (nxt_y),
    .dir     (nxt_dir),
    .addr    (nbr_addr),
    .on_grid (nbr_on_grid)
  );

  // State, slot counter and cell position registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      state <= nxt_state;
      idx   <= nxt_idx;
      x     <= nxt_x;
      y     <= nxt_y;
    end
  end

  // Next-state, slot counter and raster advance
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_x     = x;
    nxt_y     = y;
    case (state)
      ST_IDLE: begin
        if (start) begin
          nxt_state = ST_FETCH;
          nxt_idx   = '0;
          nxt_x     = '0;
          nxt_y     = '0;
        end
      end
      ST_FETCH: begin
        if (idx == IDX_bits'(IDX_LAST)) nxt_state = ST_CAPTURE;
        else                            nxt_idx   = idx + IDX_bits'(1);
      end
      ST_CAPTURE: nxt_state = ST_PRESENT;
      ST_PRESENT: begin
        if (out_valid && out_ready) begin
          if (last_cell) begin
            nxt_state = ST_DONE;
          end else begin
            nxt_state = ST_FETCH;
            nxt_idx   = '0;
            if (x == LOC_bits'(GRID_W - 1)) begin
              nxt_x = '0;
              nxt_y = y + LOC_bits'(1);
            end else begin
              nxt_x = x + LOC_bits'(1);
            end
          end
        end
      end
      ST_DONE: nxt_state = ST_IDLE;
      default: nxt_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, read strobe and assembled bundle
  always_comb begin
    busy_d      = (nxt_state == ST_FETCH) || (nxt_state == ST_CAPTURE) ||
                  (nxt_state == ST_PRESENT);
    done_d      = (nxt_state == ST_DONE);
    out_valid_d = (nxt_state == ST_PRESENT);
    rd_en_d     = 1'b0;
    rd_addr_d   = mem_rd_addr;
    flag_we     = 1'b0;
    if (nxt_state == ST_FETCH) begin
      if (nxt_idx == '0) begin
        rd_en_d   = 1'b1;
        rd_addr_d = ctr_addr;
      end else begin
        flag_we = 1'b1;
        if (nbr_on_grid) begin
          rd_en_d   = 1'b1;
          rd_addr_d = nbr_addr;
        end
      end
    end

    // Slot 8 data is still on the RAM bus during CAPTURE
    bundle = '0;
    for (int d = 0; d < 7; d++) begin
      bundle[d] = sub_flag[d+1] ? slot[0] : slot[d+1];
    end
    bundle[7] = sub_flag[8] ? slot[0] : mem_rd_data;
  end

  // Registered outputs; bundle loaded once per cell and held through PRESENT
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      busy                <= 1'b0;
      done                <= 1'b0;
      mem_rd_en           <= 1'b0;
      mem_rd_addr         <= '0;
      out_valid           <= 1'b0;
      out_loc             <= '0;
      cur_signal          <= '0;
      surrounding_signals <= '0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      mem_rd_en   <= rd_en_d;
      mem_rd_addr <= rd_addr_d;
      out_valid   <= out_valid_d;
      if (state == ST_CAPTURE) begin
        out_loc             <= cur_loc;
        cur_signal          <= slot[0];
        surrounding_signals <= bundle;
      end
    end
  end

  // Read-return capture into slots and off-grid substitution flags
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_pend  <= 1'b0;
      rd_idx   <= '0;
      slot     <= '0;
      sub_flag <= '0;
    end else begin
      rd_pend <= mem_rd_en;
      rd_idx  <= idx;
      if (rd_pend && (rd_idx != IDX_bits'(IDX_LAST))) begin
        slot[rd_idx[2:0]] <= mem_rd_data;
      end
      if (flag_we) begin
        sub_flag[nxt_idx] <= !nbr_on_grid;
      end
    end
  end

endmodule

// File: tb/tb_signal_neighborhood_fetch.sv
// Directed bench for signal_neighborhood_fetch on a 4x3 grid, RAM value = addr+1.
module tb_signal_neighborhood_fetch;

  localparam int unsigned GW = 4;
  localparam int unsigned GH = 3;
  localparam int unsigned SB = 16;
  localparam int unsigned LB = 4;

  logic                 Clk = 1'b0;
  logic                 Reset_n;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 mem_rd_en;
  logic [LB-1:0]        mem_rd_addr;
  logic [SB-1:0]        mem_rd_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [LB-1:0]        out_loc;
  logic [7:0][SB-1:0]   surrounding_signals;
  logic [SB-1:0]        cur_signal;

  signal_neighborhood_fetch #(
    .GRID_W      (GW),
    .GRID_H      (GH),
    .SIGNAL_bits (SB),
    .LOC_bits    (LB)
  ) dut (
    .Clk                 (Clk),
    .Reset_n             (Reset_n),
    .start               (start),
    .busy                (busy),
    .done                (done),
    .mem_rd_en           (mem_rd_en),
    .mem_rd_addr         (mem_rd_addr),
    .mem_rd_data         (mem_rd_data),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .out_loc             (out_loc),
    .surrounding_signals (surrounding_signals),
    .cur_signal          (cur_signal)
  );

  always #5 Clk = ~Clk;

  // Signal RAM: one-cycle read latency, contents = address + 1
  always @(posedge Clk) begin
    if (mem_rd_en)
      mem_rd_data <= (mem_rd_addr < 4'd12) ? 16'(mem_rd_addr) + 16'd1 : 16'hDEAD;
  end

  // Monitor state
  int                 cyc = 0;
  int                 rd_total = 0;
  int                 hs_n = 0;
  int                 done_n = 0;
  int                 cell_rd = 0;
  int                 cell_start = 0;
  int                 rise_cyc = 0;
  int                 done_cyc = 0;
  bit                 cell_started = 1'b0;
  bit                 prev_valid = 1'b0;
  bit                 done_busy = 1'b0;
  logic [LB-1:0]      rd_log [0:1023];
  logic [LB-1:0]      hs_loc [0:63];
  logic [SB-1:0]      hs_cur [0:63];
  logic [7:0][SB-1:0] hs_sur [0:63];
  int                 hs_rd  [0:63];
  int                 hs_lat [0:63];
  int                 hs_cyc [0:63];

  // Sample the interface mid-cycle and log reads, handshakes and done pulses
  always @(negedge Clk) begin
    cyc++;
    if (!Reset_n) begin
      cell_rd      = 0;
      cell_started = 1'b0;
    end
    if (mem_rd_en) begin
      if (rd_total < 1024) rd_log[rd_total] = mem_rd_addr;
      rd_total++;
      cell_rd++;
      if (!cell_started) begin
        cell_started = 1'b1;
        cell_start   = cyc;
      end
    end
    if (out_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = out_valid;
    if (out_valid && out_ready) begin
      if (hs_n < 64) begin
        hs_loc[hs_n] = out_loc;
        hs_cur[hs_n] = cur_signal;
        hs_sur[hs_n] = surrounding_signals;
        hs_rd[hs_n]  = cell_rd;
        hs_lat[hs_n] = rise_cyc - cell_start;
        hs_cyc[hs_n] = cyc;
      end
      hs_n++;
      cell_rd      = 0;
      cell_started = 1'b0;
    end
    if (done) begin
      done_n++;
      done_cyc  = cyc;
      done_busy = busy;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Hand-computed neighbourhoods: N, NE, E, SE, S, SW, W, NW
  int cell_id  [4]    = '{0, 3, 5, 11};
  int cell_cur [4]    = '{1, 4, 6, 12};
  int cell_sur [4][8] = '{'{1, 1, 2, 6, 5, 1, 1, 1},
                          '{4, 4, 4, 4, 8, 7, 3, 4},
                          '{2, 3, 7, 11, 10, 9, 5, 1},
                          '{8, 12, 12, 12, 12, 12, 11, 7}};
  int rd_exp   [12]   = '{4, 6, 6, 4, 6, 9, 9, 6, 4, 6, 6, 4};
  int loc0_addr[4]    = '{0, 1, 5, 4};

  logic [7:0][SB-1:0] sur6;
  int t;
  int hb;
  int rb;
  int db;
  int rd_snap;
  int set_cyc;

  initial begin
    sur6 = {16'd2, 16'd6, 16'd10, 16'd11, 16'd12, 16'd8, 16'd4, 16'd3};
    Reset_n   = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_valid", out_valid, 0);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_out_loc", out_loc, 0);
    check("rst_cur", cur_signal, 0);
    check("rst_sur", surrounding_signals, 0);

    Reset_n = 1'b1;
    step();

    // Sweep 1: plain sweep, with a start pulse while busy at loc 3
    hb = hs_n; rb = rd_total; db = done_n;
    start = 1'b1;
    step();
    start = 1'b0;
    check("s1_busy_after_start", busy, 1);
    check("s1_first_rd_en", mem_rd_en, 1);
    check("s1_first_rd_addr", mem_rd_addr, 0);

    t = 0;
    while (!(out_valid && out_loc == 4'd3) && t < 200) begin step(); t++; end
    check("s1_wait_loc3", 32'(t < 200), 1);
    start = 1'b1;
    step();
    start = 1'b0;

    t = 0;
    while (done_n == db && t < 600) begin step(); t++; end
    check("s1_wait_done", 32'(t < 600), 1);
    repeat (3) step();

    check("s1_hs_count", hs_n - hb, 12);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("s1_loc_order%0d", i), hs_loc[hb+i], i);
      check($sformatf("s1_reads_loc%0d", i), hs_rd[hb+i], rd_exp[i]);
    end
    for (int c = 0; c < 4; c++) begin
      check($sformatf("s1_cur_loc%0d", cell_id[c]), hs_cur[hb+cell_id[c]], cell_cur[c]);
      for (int d = 0; d < 8; d++)
        check($sformatf("s1_sur_loc%0d_d%0d", cell_id[c], d),
              hs_sur[hb+cell_id[c]][d], cell_sur[c][d]);
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("s1_loc0_rd_addr%0d", i), rd_log[rb+i], loc0_addr[i]);
    check("s1_latency_loc0", hs_lat[hb], 10);
    check("s1_latency_loc5", hs_lat[hb+5], 10);
    check("s1_throughput", hs_cyc[hb+1] - hs_cyc[hb], 11);
    check("s1_done_count", done_n - db, 1);
    check("s1_done_after_last_hs", done_cyc - hs_cyc[hb+11], 1);
    check("s1_busy_in_done", done_busy, 0);
    check("s1_busy_after", busy, 0);
    check("s1_done_after", done, 0);

    // Sweep 2: backpressure at loc 6
    hb = hs_n; db = done_n;
    start = 1'b1;
    step();
    start = 1'b0;
    t = 0;
    while (!(hs_n == hb + 6 && !out_valid) && t < 200) begin step(); t++; end
    check("s2_wait_loc6_fetch", 32'(t < 200), 1);
    out_ready = 1'b0;
    t = 0;
    while (!out_valid && t < 40) begin step(); t++; end
    check("s2_wait_loc6_valid", 32'(t < 40), 1);
    rd_snap = rd_total;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("s2_stall%0d_valid", k), out_valid, 1);
      check($sformatf("s2_stall%0d_loc", k), out_loc, 6);
      check($sformatf("s2_stall%0d_cur", k), cur_signal, 7);
      check($sformatf("s2_stall%0d_sur", k), surrounding_signals, sur6);
      check($sformatf("s2_stall%0d_rd_en", k), mem_rd_en, 0);
      step();
    end
    check("s2_no_reads_in_stall", rd_total - rd_snap, 0);
    check("s2_still_valid", out_valid, 1);
    out_ready = 1'b1;
    set_cyc = cyc;
    step();
    check("s2_accepted_count", hs_n - hb, 7);
    check("s2_accepted_loc", hs_loc[hb+6], 6);
    check("s2_accept_cycle", hs_cyc[hb+6], set_cyc + 1);
    check("s2_valid_drop", out_valid, 0);
    t = 0;
    while (done_n == db && t < 600) begin step(); t++; end
    check("s2_wait_done", 32'(t < 600), 1);
    check("s2_hs_count", hs_n - hb, 12);
    repeat (3) step();

    // Sweep 3: asynchronous reset at FETCH idx 4 of loc 7
    hb = hs_n; db = done_n;
    start = 1'b1;
    step();
    start = 1'b0;
    t = 0;
    while (!(hs_n == hb + 7 && mem_rd_en) && t < 200) begin step(); t++; end
    check("s3_wait_loc7_fetch", 32'(t < 200), 1);
    check("s3_loc7_ctr_addr", mem_rd_addr, 7);
    repeat (4) step();
    check("s3_busy_before_rst", busy, 1);
    check("s3_rd_en_idx4", mem_rd_en, 0);
    check("s3_addr_held_idx4", mem_rd_addr, 3);
    Reset_n = 1'b0;
    #1;
    check("s3_rst_busy", busy, 0);
    check("s3_rst_rd_en", mem_rd_en, 0);
    check("s3_rst_rd_addr", mem_rd_addr, 0);
    check("s3_rst_valid", out_valid, 0);
    check("s3_rst_out_loc", out_loc, 0);
    check("s3_rst_cur", cur_signal, 0);
    check("s3_rst_sur", surrounding_signals, 0);
    repeat (3) step();
    Reset_n = 1'b1;
    repeat (20) step();
    check("s3_no_done", done_n - db, 0);
    check("s3_idle_busy", busy, 0);

    // Sweep 4: fresh start after reset begins at loc 0
    hb = hs_n; db = done_n;
    start = 1'b1;
    step();
    start = 1'b0;
    t = 0;
    while (done_n == db && t < 600) begin step(); t++; end
    check("s4_wait_done", 32'(t < 600), 1);
    check("s4_hs_count", hs_n - hb, 12);
    check("s4_first_loc", hs_loc[hb], 0);
    check("s4_first_cur", hs_cur[hb], 1);
    check("s4_last_loc", hs_loc[hb+11], 11);
    check("s4_done_count", done_n - db, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop if the directed sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
